// File: rtl/mp_cmd_queue.sv
// mp_cmd_queue: four independent per-core command FIFOs sitting between the
// message-passing unit (producer) and the per-core thread dispatchers (consumer).
// Optional feature: define MP_CMDQ_REFUSE_CNT_EN to build saturating 16-bit
// per-core counters of offers refused because the queue was full.

module mp_cmdq_lane #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        access_i,
    input  logic [13:0] pc_i,
    input  logic [31:0] data_i,
    input  logic        ready_i,
    output logic        ack_o,
    output logic        valid_o,
    output logic [13:0] pc_o,
    output logic [31:0] data_o,
    output logic [4:0]  level_o,
    output logic [15:0] refused_o
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_LVL = 5'(DEPTH);

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ack_q;
    logic [13:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic          full, push, pop;

    // Full uses the registered count, so a same-cycle pop never frees a slot
    assign full    = (cnt_q == FULL_LVL);
    assign push    = access_i & ~full;
    assign pop     = (cnt_q != 5'd0) & ready_i;

    // Pointer and occupancy next-state; power-of-2 depth makes pointer wrap free
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + 5'(push) - 5'(pop);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push) wr_d = wr_q + AW'(1);
    end

    // Pointer, count and ack registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ack_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ack_q <= push;
        end
    end

    // Entry storage, cleared on reset so stale commands never reappear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_q]   <= pc_i;
            data_mem_q[wr_q] <= data_i;
        end
    end

    assign ack_o   = ack_q;
    assign valid_o = (cnt_q != 5'd0);
    assign pc_o    = valid_o ? pc_mem_q[rd_q]   : '0;
    assign data_o  = valid_o ? data_mem_q[rd_q] : '0;
    assign level_o = cnt_q;

`ifdef MP_CMDQ_REFUSE_CNT_EN
    logic [15:0] ref_q;

    // Count each cycle an offer is turned away by a full queue, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ref_q <= '0;
        else if (access_i && full && (ref_q != 16'hFFFF))
            ref_q <= ref_q + 16'd1;
    end

    assign refused_o = ref_q;
`else
    assign refused_o = '0;
`endif

endmodule

module mp_cmd_queue #(
    parameter int MP_CMDQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [3:0]   mp_access,
    input  logic [55:0]  mp_command_pc_in,
    input  logic [127:0] mp_command_data_in,
    output logic [3:0]   mp_access_ack,
    output logic [3:0]   cmd_valid,
    output logic [55:0]  cmd_pc_out,
    output logic [127:0] cmd_data_out,
    input  logic [3:0]   cmd_ready,
    output logic [19:0]  cmd_level,
    output logic [63:0]  mp_cmd_refused_cnt
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][13:0] pc_in_w, pc_out_w;
    logic [NUM_LANES-1:0][31:0] data_in_w, data_out_w;
    logic [NUM_LANES-1:0][4:0]  level_w;
    logic [NUM_LANES-1:0][15:0] refused_w;

    assign pc_in_w            = mp_command_pc_in;
    assign data_in_w          = mp_command_data_in;
    assign cmd_pc_out         = pc_out_w;
    assign cmd_data_out       = data_out_w;
    assign cmd_level          = level_w;
    assign mp_cmd_refused_cnt = refused_w;

    // One fully independent queue per core
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mp_cmdq_lane #(.DEPTH(MP_CMDQ_DEPTH)) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .access_i  (mp_access[k]),
            .pc_i      (pc_in_w[k]),
            .data_i    (data_in_w[k]),
            .ready_i   (cmd_ready[k]),
            .ack_o     (mp_access_ack[k]),
            .valid_o   (cmd_valid[k]),
            .pc_o      (pc_out_w[k]),
            .data_o    (data_out_w[k]),
            .level_o   (level_w[k]),
            .refused_o (refused_w[k])
        );
    end

endmodule

// File: tb/tb_mp_cmd_queue.sv
// Self-checking bench for mp_cmd_queue: a behavioural per-core queue model
// acts as scoreboard; entries are pushed when an accepted offer is driven and
// popped and compared when the DUT presents them to a ready consumer.

module tb_mp_cmd_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [13:0] pc;
        logic [31:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   mp_access;
    logic [55:0]  mp_command_pc_in;
    logic [127:0] mp_command_data_in;
    logic [3:0]   mp_access_ack;
    logic [3:0]   cmd_valid;
    logic [55:0]  cmd_pc_out;
    logic [127:0] cmd_data_out;
    logic [3:0]   cmd_ready;
    logic [19:0]  cmd_level;
    logic [63:0]  mp_cmd_refused_cnt;

    ent_t        sb [4][$];
    logic [15:0] ref_m [4];
    int          n_cmp = 0;
    int          n_err = 0;

    mp_cmd_queue #(.MP_CMDQ_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .mp_access          (mp_access),
        .mp_command_pc_in   (mp_command_pc_in),
        .mp_command_data_in (mp_command_data_in),
        .mp_access_ack      (mp_access_ack),
        .cmd_valid          (cmd_valid),
        .cmd_pc_out         (cmd_pc_out),
        .cmd_data_out       (cmd_data_out),
        .cmd_ready          (cmd_ready),
        .cmd_level          (cmd_level),
        .mp_cmd_refused_cnt (mp_cmd_refused_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model state
    task automatic chk_outs(input logic [3:0] e_ack);
        logic [3:0]   e_vld;
        logic [19:0]  e_lvl;
        logic [55:0]  e_pc;
        logic [127:0] e_dat;
        logic [63:0]  e_ref;
        e_vld = '0; e_lvl = '0; e_pc = '0; e_dat = '0; e_ref = '0;
        for (int k = 0; k < 4; k++) begin
            e_lvl[5*k +: 5] = 5'(sb[k].size());
            if (sb[k].size() != 0) begin
                e_vld[k]         = 1'b1;
                e_pc[14*k +: 14] = sb[k][0].pc;
                e_dat[32*k +: 32] = sb[k][0].data;
            end
`ifdef MP_CMDQ_REFUSE_CNT_EN
            e_ref[16*k +: 16] = ref_m[k];
`endif
        end
        chk("ack",     128'(mp_access_ack),      128'(e_ack));
        chk("valid",   128'(cmd_valid),          128'(e_vld));
        chk("level",   128'(cmd_level),          128'(e_lvl));
        chk("pc",      128'(cmd_pc_out),         128'(e_pc));
        chk("data",    cmd_data_out,             e_dat);
        chk("refused", 128'(mp_cmd_refused_cnt), 128'(e_ref));
    endtask

    // One clock cycle: drive, predict, clock, update model, compare
    task automatic cyc(input logic [3:0] acc, input logic [55:0] pc,
                       input logic [127:0] dat, input logic [3:0] rdy);
        logic [3:0] e_push, e_pop;
        mp_access          = acc;
        mp_command_pc_in   = pc;
        mp_command_data_in = dat;
        cmd_ready          = rdy;
        #1;
        for (int k = 0; k < 4; k++) begin
            e_pop[k]  = (sb[k].size() != 0) && rdy[k];
            e_push[k] = acc[k] && (sb[k].size() < DEPTH);
            if (acc[k] && sb[k].size() == DEPTH && ref_m[k] != 16'hFFFF)
                ref_m[k] = ref_m[k] + 16'd1;
            if (e_pop[k])
                chk("pop_data", 128'(cmd_data_out[32*k +: 32]), 128'(sb[k][0].data));
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (e_pop[k])  void'(sb[k].pop_front());
            if (e_push[k]) sb[k].push_back('{pc[14*k +: 14], dat[32*k +: 32]});
        end
        chk_outs(e_push);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            ref_m[k] = '0;
        end
    endtask

    initial begin
        logic [55:0]  rp;
        logic [127:0] rd;
        rstn = 1'b0;
        mp_access = '0; mp_command_pc_in = '0; mp_command_data_in = '0; cmd_ready = '0;
        clear_model();
        #3;
        chk_outs(4'b0000);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Single push on core 0
        cyc(4'b0001, 56'h0123, 128'hDEADBEEF, 4'b0000);
        chk("single_ack",  128'(mp_access_ack), 128'(4'b0001));
        chk("single_pc",   128'(cmd_pc_out[13:0]), 128'(14'h0123));
        chk("single_data", 128'(cmd_data_out[31:0]), 128'(32'hDEADBEEF));
        chk("single_lvl",  128'(cmd_level[4:0]), 128'(5'd1));
        cyc(4'b0000, '0, '0, 4'b0001);

        // Core 2: five offers into depth-4 queue, fifth refused
        for (int i = 1; i <= 5; i++)
            cyc(4'b0100, 56'(i) << 28, 128'(i) << 64, 4'b0000);
        chk("full_lvl",   128'(cmd_level[14:10]), 128'(5'd4));
        chk("full_noack", 128'(mp_access_ack[2]), 128'(1'b0));
`ifdef MP_CMDQ_REFUSE_CNT_EN
        chk("full_refcnt", 128'(mp_cmd_refused_cnt[47:32]), 128'(16'd1));
`else
        chk("full_refcnt", 128'(mp_cmd_refused_cnt[47:32]), 128'(16'd0));
`endif
        for (int i = 0; i < 4; i++) cyc(4'b0000, '0, '0, 4'b0100);

        // Core 1: full plus same-cycle pop, then retry
        for (int i = 0; i < 4; i++) cyc(4'b0010, '0, 128'(32'hA0 + i) << 32, 4'b0000);
        cyc(4'b0010, '0, 128'(32'hAF) << 32, 4'b0010);
        chk("fullpop_noack", 128'(mp_access_ack[1]), 128'(1'b0));
        chk("fullpop_lvl",   128'(cmd_level[9:5]), 128'(5'd3));
        cyc(4'b0010, '0, 128'(32'hAF) << 32, 4'b0000);
        chk("retry_ack", 128'(mp_access_ack[1]), 128'(1'b1));
        chk("retry_lvl", 128'(cmd_level[9:5]), 128'(5'd4));
        for (int i = 0; i < 4; i++) cyc(4'b0000, '0, '0, 4'b0010);

        // Core 3 wrap-around: ten push/pop pairs, level stays at 1
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1000, 56'(14'h100 + i) << 42, 128'(32'h10 + i) << 96, 4'b1000);
            chk("wrap_lvl", 128'(cmd_level[19:15]), 128'(5'd1));
        end
        cyc(4'b0000, '0, '0, 4'b1000);

        // Random traffic on all cores
        for (int i = 0; i < 300; i++) begin
            rp = 56'({$urandom(), $urandom()});
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc(4'($urandom()), rp, rd, 4'($urandom_range(0, 15) & 4'($urandom())));
        end
        for (int i = 0; i < DEPTH; i++) cyc(4'b0000, '0, '0, 4'b1111);

        // All cores push together, then reset mid-stream
        cyc(4'b1111, 56'h0AAA_1BBB_2CCC_3DD, 128'h11111111_22222222_33333333_44444444, 4'b0000);
        chk("all_ack", 128'(mp_access_ack), 128'(4'b1111));
        cyc(4'b1111, 56'h0123_4567_89AB_CDE, 128'h55555555_66666666_77777777_88888888, 4'b0000);
        mp_access = 4'b1111;
        #2 rstn = 1'b0;
        #1;
        clear_model();
        chk("rst_valid", 128'(cmd_valid), 128'(4'b0000));
        chk("rst_level", 128'(cmd_level), 128'(20'd0));
        chk_outs(4'b0000);
        mp_access = '0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        cyc(4'b0101, 56'h0000_0000_0042_1, 128'h0_0_CAFEF00D_0_0BADF00D, 4'b0000);
        chk("post_rst_ack", 128'(mp_access_ack), 128'(4'b0101));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mp_cmd_queue.md
MP_CMD_QUEUE -- requirements
Module: mp_cmd_queue

Interface
REQ-001 SHALL provide parameter MP_CMDQ_DEPTH, default 4, meaning command entries per core (power of 2, 2..16).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have: mp_access  input  4  per-core command offer from the message-passing unit.
REQ-004 SHALL have: mp_command_pc_in  input  56  4x14-bit target PC, core k in bits [14k+13:14k].
REQ-005 SHALL have: mp_command_data_in  input  128  4x32-bit message, core k in bits [32k+31:32k].
REQ-006 SHALL have: mp_access_ack  output  4  per-core acceptance, registered.
REQ-007 SHALL have: cmd_valid  output  4  per-core head entry valid.
REQ-008 SHALL have: cmd_pc_out  output  56  head PC per core, same packing as mp_command_pc_in.
REQ-009 SHALL have: cmd_data_out  output  128  head message per core, same packing as mp_command_data_in.
REQ-010 SHALL have: cmd_ready  input  4  per-core consumer (thread dispatcher) ready.
REQ-011 SHALL have: cmd_level  output  20  4x5-bit occupancy, core k in [5k+4:5k].
REQ-012 SHALL have: mp_cmd_refused_cnt  output  64  4x16-bit refusal counters (see Configuration).

Function
REQ-013 SHALL keep four independent circular FIFOs (one per core k), each with read and write pointers of log2(MP_CMDQ_DEPTH) bits wrapping modulo depth and a count of 0..MP_CMDQ_DEPTH.
REQ-014 Push for core k SHALL occur at the clock edge when mp_access[k]=1 and count_k<MP_CMDQ_DEPTH, writing PC and data slices k at the write pointer.
REQ-015 mp_access_ack[k] SHALL be 1 for exactly the cycle after each push, else 0; one offer yields at most one push.
REQ-016 When count_k=MP_CMDQ_DEPTH, mp_access[k] SHALL be refused: no write, no ack, offer ignored until retried by the upstream unit.
REQ-017 Full SHALL be evaluated on the registered count; a pop in the same cycle SHALL NOT make room for a push in that cycle.
REQ-018 cmd_valid[k] SHALL equal (count_k!=0); cmd_pc_out/cmd_data_out slice k SHALL show the entry at the read pointer, and SHALL be 0 when empty.
REQ-019 Pop SHALL occur at the edge when cmd_valid[k]&cmd_ready[k]; cmd_ready with empty FIFO SHALL have no effect.
REQ-020 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged and advance both pointers.
REQ-021 Latency: a push into an empty FIFO SHALL make cmd_valid[k]=1 on the next cycle (no combinational bypass).
REQ-022 Entries SHALL leave in push order per core; cores SHALL not interact.
REQ-023 cmd_level slice k SHALL equal count_k.

Reset
REQ-024 rstn low SHALL asynchronously clear pointers, counts, storage, mp_access_ack, and refusal counters; cmd_valid, cmd_pc_out, cmd_data_out, cmd_level SHALL read 0.
REQ-025 Reset mid-operation SHALL discard all queued commands; first cycle after release SHALL accept pushes normally.

Configuration
REQ-026 With macro MP_CMDQ_REFUSE_CNT_EN defined, mp_cmd_refused_cnt slice k SHALL increment by 1 each cycle mp_access[k]=1 is refused by REQ-016, saturating at 16'hFFFF.
REQ-027 Without MP_CMDQ_REFUSE_CNT_EN, mp_cmd_refused_cnt SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-028 Single push: reset, mp_access=4'b0001, pc slice0=14'h0123, data slice0=32'hDEADBEEF for 1 cycle -> next cycle mp_access_ack=4'b0001, cmd_valid[0]=1, cmd_pc_out[13:0]=14'h0123, cmd_data_out[31:0]=32'hDEADBEEF, cmd_level[4:0]=1.
REQ-029 Full: cmd_ready=0, push 5 offers on core 2 with data 1..5 -> level 4, 5th offer gets no ack, refused_cnt[47:32]=1 (macro on) or 0 (off); then cmd_ready[2]=1 -> data pops 1,2,3,4 in order.
REQ-030 Full with simultaneous pop: core 1 count=4, mp_access[1]=1 and cmd_ready[1]=1 same cycle -> no ack, count 3; re-offer next cycle -> ack, count 4.
REQ-031 Wrap-around: 10 push/pop pairs with data 32'h10..32'h19 on core 3 at depth 4 -> outputs in order, level never exceeds 1, pointers wrap cleanly.
REQ-032 Concurrency and reset: all four cores push simultaneously distinct data -> ack=4'b1111, per-core heads correct; assert rstn low mid-stream -> cmd_valid=0, level=0 immediately.
